bram_bubble_sorter: RTL and testbench

//  - In-place sort engine for the single-port sort BRAM (ADDR_WIDTH addr, DATA_WIDTH data, 1-cycle read).
//  - Sits directly on the BRAM port (we/addr/di out, do in): reads adjacent pairs, compares, writes back swapped.
//  - Bubble sort with early exit on a swap-free pass; reports completion and total swap count.

---
 rtl/bram_bubble_sorter.sv | 195 +++++++++++++++++++
 tb/tb_bram_bubble_sorter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_bubble_sorter.sv
// -----------------------------------------------------------------------------
// bram_bubble_sorter
//
// In-place bubble sort engine that drives a single-port BRAM directly
// (1-cycle read latency). It reads each adjacent pair, compares the two
// values, and writes the pair back swapped when they are out of order.
// A pass with no swaps ends the sort early. The engine reports completion
// and the total number of swaps.
//
// Build option:
//   SORT_DESCEND_EN  when defined, swaps on a < b, so the result is
//                    descending. Undefined by default, which gives an
//                    ascending sort that swaps on a > b. Timing is the same
//                    in both builds.
//
// Parameters:
//   ADDR_WIDTH  BRAM address width; all DEPTH = 2**ADDR_WIDTH entries are sorted
//   DATA_WIDTH  element width; elements are compared as unsigned values
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       sort request; only sampled while idle
//   busy        high whenever the engine is not idle
//   done        one-cycle pulse when the sort completes
//   mem_we      BRAM write enable
//   mem_addr    BRAM address
//   mem_di      BRAM write data
//   mem_do      BRAM read data; valid the cycle after the address is presented
//   swap_count  swaps performed in the last/current sort; cleared on start
// -----------------------------------------------------------------------------
module bram_bubble_sorter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_di,
    input  logic [DATA_WIDTH-1:0]   mem_do,
    output logic [2*ADDR_WIDTH-1:0] swap_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] i;        // index of the left element of the pair
    logic [ADDR_WIDTH-1:0] limit;    // number of pairs compared in this pass
    logic [DATA_WIDTH-1:0] a, b;     // left / right operand
    logic                  swapped;  // a swap happened earlier in this pass

    logic swap_cond;
    logic more_pairs;
    logic pass_swapped;
    logic end_sort;
    logic advance;

    // The right operand arrives on mem_do during CMP, in the same cycle it
    // is registered into b, so the compare uses mem_do directly.
`ifdef SORT_DESCEND_EN
    assign swap_cond = (a < mem_do);
`else
    assign swap_cond = (a > mem_do);
`endif

    // Compare in ADDR_WIDTH+1 bits so that i+1 cannot wrap.
    assign more_pairs = ({1'b0, i} + (ADDR_WIDTH + 1)'(1)) < {1'b0, limit};

    // swapped is only written at the end of WR_B. A swap on the last pair of
    // a pass must still count, so the swap in flight is included here.
    assign pass_swapped = swapped || (state == S_WR_B);
    assign end_sort     = !pass_swapped || (limit == ONE);
    assign advance      = ((state == S_CMP) && !swap_cond) || (state == S_WR_B);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments (<=), so every
    // flop samples its pre-edge value no matter how the blocks are ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: assign a default first in combinational blocks. Any path that
        // leaves a signal unassigned would infer a latch.
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RD_A;
            S_RD_A: state_next = S_RD_B;
            S_RD_B: state_next = S_CMP;
            S_CMP: begin
                if (swap_cond)       state_next = S_WR_A;
                else if (more_pairs) state_next = S_RD_A;
                else if (end_sort)   state_next = S_DONE;
                else                 state_next = S_RD_A;
            end
            S_WR_A: state_next = S_WR_B;
            S_WR_B: begin
                if (more_pairs)    state_next = S_RD_A;
                else if (end_sort) state_next = S_DONE;
                else               state_next = S_RD_A;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        case (state)
            S_RD_A: mem_addr = i;
            S_RD_B: mem_addr = i + ONE;
            S_WR_A: begin
                mem_we   = 1'b1;
                mem_addr = i;
                mem_di   = b;
            end
            S_WR_B: begin
                mem_we   = 1'b1;
                mem_addr = i + ONE;
                mem_di   = a;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i          <= '0;
            limit      <= LAST_PAIR;
            a          <= '0;
            b          <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i          <= '0;
                        limit      <= LAST_PAIR;
                        swapped    <= 1'b0;
                        swap_count <= '0;
                    end
                end
                S_RD_B: a <= mem_do;
                S_CMP:  b <= mem_do;
                S_WR_B: begin
                    swapped    <= 1'b1;
                    swap_count <= swap_count + 1'b1;
                end
                default: ;
            endcase

            // Pair advance. A new pass clears swapped, and because this
            // assignment comes after the one in WR_B, the clear takes effect.
            if (advance) begin
                if (more_pairs) begin
                    i <= i + ONE;
                end else if (!end_sort) begin
                    limit   <= limit - ONE;
                    i       <= '0;
                    swapped <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_bubble_sorter.sv
// -----------------------------------------------------------------------------
// tb_bram_bubble_sorter
//
// Self-checking bench for bram_bubble_sorter. A behavioural single-port BRAM
// sits on the sorter's port. Expected results come from a histogram sort, and
// the expected swap count is the number of strict inversions in the input.
// -----------------------------------------------------------------------------
module tb_bram_bubble_sorter;

    localparam int AW     = 3;
    localparam int DW     = 4;
    localparam int DEPTH  = 8;
    localparam int BUDGET = 600;

`ifdef SORT_DESCEND_EN
    localparam bit DESCEND = 1'b1;
`else
    localparam bit DESCEND = 1'b0;
`endif

    typedef logic [DW-1:0] arr_t [DEPTH];

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_di;
    logic [DW-1:0]   mem_do;
    logic [2*AW-1:0] swap_count;

    int checks = 0;
    int errors = 0;

    // Behavioural BRAM; the bench fills it through load_en so that only one
    // process ever writes mem.
    arr_t mem;
    arr_t load_data;
    logic load_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= load_data[k];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_di;
        end
        mem_do <= mem[mem_addr];
    end

    bram_bubble_sorter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_di     (mem_di),
        .mem_do     (mem_do),
        .swap_count (swap_count)
    );

    // ---------------------------------------------------------------- model
    function automatic arr_t model_sorted(input arr_t src);
        int   hist [16];
        int   n;
        arr_t r;
        for (int v = 0; v < 16; v++) hist[v] = 0;
        for (int k = 0; k < DEPTH; k++) hist[src[k]]++;
        n = 0;
        for (int v = 0; v < 16; v++) begin
            int val;
            val = DESCEND ? 15 - v : v;
            for (int c = 0; c < hist[val]; c++) begin
                r[n] = DW'(val);
                n++;
            end
        end
        return r;
    endfunction

    function automatic int model_swaps(input arr_t src);
        int inv;
        inv = 0;
        for (int x = 0; x < DEPTH; x++)
            for (int y = x + 1; y < DEPTH; y++)
                if (DESCEND ? (src[x] < src[y]) : (src[x] > src[y])) inv++;
        return inv;
    endfunction

    function automatic logic [31:0] pack(input arr_t v);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < DEPTH; k++) p = {p[27:0], v[k]};
        return p;
    endfunction

    function automatic arr_t ramp(input bit down);
        arr_t r;
        for (int k = 0; k < DEPTH; k++) r[k] = DW'(down ? DEPTH - 1 - k : k);
        return r;
    endfunction

    // -------------------------------------------------------------- helpers
    task automatic load(input arr_t v);
        @(negedge clk);
        load_data = v;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Pulses start for one cycle, then follows the sort until done. cyc is
    // the cycle number after the start edge in which done was seen. When
    // pulse_at is nonzero, start is pulsed again in that cycle.
    task automatic run_sort(input int pulse_at, output int cyc,
                            output int writes, output int dones);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
        writes = 0;
        dones  = 0;
        while (cyc < BUDGET) begin
            if (mem_we) writes++;
            if (done) begin
                dones++;
                break;
            end
            start = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, mem_we, mem_addr, mem_di, swap_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b we=%b addr=%0d di=%0h sc=%0d, want all 0",
                     busy, done, mem_we, mem_addr, mem_di, swap_count);
        end
        rst = 1'b0;
        load(ramp(!DESCEND));
        // Start and keep start high, run a while, then pulse rst mid-cycle.
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!mem_we && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: got busy=%b, want 1", busy);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_we, swap_count} !== '0) begin
            errors++;
            $display("FAIL reset_async: got busy=%b done=%b we=%b sc=%0d, want all 0",
                     busy, done, mem_we, swap_count);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reverse();
        arr_t src;
        int   cyc, writes, dones;
        src = ramp(!DESCEND);
        load(src);
        run_sort(0, cyc, writes, dones);
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL reverse_done: got %0d done pulses within %0d cycles, want 1", dones, BUDGET);
        end
        checks++;
        if (pack(mem) !== pack(model_sorted(src))) begin
            errors++;
            $display("FAIL reverse_data: got %h, want %h", pack(mem), pack(model_sorted(src)));
        end
        checks++;
        if (swap_count !== 28) begin
            errors++;
            $display("FAIL reverse_swaps: got %0d, want 28", swap_count);
        end
        checks++;
        if (writes !== 56) begin
            errors++;
            $display("FAIL reverse_writes: got %0d, want 56", writes);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reverse_idle_after: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_sorted();
        arr_t src;
        int   cyc, writes, dones;
        src = ramp(DESCEND);
        load(src);
        run_sort(0, cyc, writes, dones);
        checks++;
        if (cyc !== 22 || dones !== 1) begin
            errors++;
            $display("FAIL sorted_latency: got done in cycle %0d (pulses %0d), want cycle 22", cyc, dones);
        end
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL sorted_no_write: got %0d write cycles, want 0", writes);
        end
        checks++;
        if (swap_count !== 0) begin
            errors++;
            $display("FAIL sorted_swaps: got %0d, want 0", swap_count);
        end
        checks++;
        if (pack(mem) !== pack(src)) begin
            errors++;
            $display("FAIL sorted_data: got %h, want %h", pack(mem), pack(src));
        end
    endtask

    task automatic test_duplicates();
        arr_t src;
        int   cyc, writes, dones;
        src = '{4'h3, 4'h3, 4'h1, 4'h1, 4'hF, 4'h0, 4'hF, 4'h2};
        load(src);
        run_sort(0, cyc, writes, dones);
        checks++;
        if (dones !== 1 || pack(mem) !== pack(model_sorted(src))) begin
            errors++;
            $display("FAIL dup_data: got %h (pulses %0d), want %h", pack(mem), dones, pack(model_sorted(src)));
        end
        // Every write pair must fix one strict inversion, so equal pairs add none.
        checks++;
        if (writes !== 2 * model_swaps(src) || swap_count !== model_swaps(src)) begin
            errors++;
            $display("FAIL dup_stable: got writes=%0d swaps=%0d, want writes=%0d swaps=%0d",
                     writes, swap_count, 2 * model_swaps(src), model_swaps(src));
        end
    endtask

    task automatic test_busy_start();
        arr_t src;
        int   cyc, writes, dones;
        bit   restarted;
        for (int k = 0; k < DEPTH; k++) src[k] = DW'($urandom_range(0, 15));
        load(src);
        run_sort(5, cyc, writes, dones);
        checks++;
        if (dones !== 1 || pack(mem) !== pack(model_sorted(src))) begin
            errors++;
            $display("FAIL busy_start_data: got %h (pulses %0d), want %h", pack(mem), dones, pack(model_sorted(src)));
        end
        restarted = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy) restarted = 1'b1;
        end
        checks++;
        if (restarted !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ignored: got busy=1 after done, want idle");
        end
    endtask

    task automatic test_reset_mid_write();
        arr_t src, expect_mem;
        int   n, cyc, writes, dones;
        src = ramp(!DESCEND);
        load(src);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!mem_we && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL midwr_reach: got no write within %0d cycles, want one", BUDGET);
        end
        @(negedge clk);            // WR_B: the first element is already written
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_we, swap_count} !== '0) begin
            errors++;
            $display("FAIL midwr_reset: got busy=%b done=%b we=%b sc=%0d, want all 0",
                     busy, done, mem_we, swap_count);
        end
        @(negedge clk);
        rst = 1'b0;
        expect_mem    = src;
        expect_mem[0] = src[1];
        checks++;
        if (pack(mem) !== pack(expect_mem)) begin
            errors++;
            $display("FAIL midwr_partial: got %h, want %h", pack(mem), pack(expect_mem));
        end
        run_sort(0, cyc, writes, dones);
        checks++;
        if (dones !== 1 || pack(mem) !== pack(model_sorted(expect_mem)) ||
            swap_count !== model_swaps(expect_mem)) begin
            errors++;
            $display("FAIL midwr_restart: got %h sc=%0d pulses=%0d, want %h sc=%0d",
                     pack(mem), swap_count, dones, pack(model_sorted(expect_mem)), model_swaps(expect_mem));
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midwr_done_once: got done=%b after pulse, want 0", done);
        end
    endtask

    task automatic test_random();
        arr_t src;
        int   cyc, writes, dones;
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < DEPTH; k++) src[k] = DW'($urandom_range(0, 15));
            load(src);
            run_sort(0, cyc, writes, dones);
            checks++;
            if (dones !== 1 || pack(mem) !== pack(model_sorted(src)) ||
                swap_count !== model_swaps(src)) begin
                errors++;
                $display("FAIL random_%0d: src %h got %h sc=%0d, want %h sc=%0d",
                         t, pack(src), pack(mem), swap_count, pack(model_sorted(src)), model_swaps(src));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_reverse();
        test_sorted();
        test_duplicates();
        test_busy_start();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
